imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/ssp_pkg.sv | 6 +
 rtl/imem_array.sv | 19 +
 rtl/imem_loader.sv | 83 ++++++++
 tb/tb_imem_loader.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/ssp_pkg.sv
// ssp_pkg: shared memory geometry and loader FSM state encoding.
package ssp_pkg;
    localparam int IMEM_DEPTH  = 64;
    localparam int IMEM_ADDR_W = 6;
    typedef enum logic [2:0] {IDLE, HDR, DATA, DONE, ERR} load_state_t;
endpackage

// File: rtl/imem_array.sv
// imem_array: DEPTH x 32 instruction store, synchronous write, asynchronous read.
module imem_array
    import ssp_pkg::*;
#(
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int ADDR_W = IMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);
    logic [31:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/imem_loader.sv
// imem_loader: serial byte loader that fills the instruction memory and
// holds the processor until a complete program has been written.
module imem_loader
    import ssp_pkg::*;
#(
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int ADDR_W = IMEM_ADDR_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_start,
    input  logic [7:0]      byte_in,
    input  logic            byte_valid,
    output logic            byte_ready,
    input  logic [31:0]     PC,
    output logic [31:0]     instr,
    output logic            cpu_hold,
    output logic            load_done,
    output logic            load_err,
    output logic [ADDR_W:0] word_count
);
    load_state_t     state, nxt;
    logic [1:0]      byte_cnt;
    logic [23:0]     asm_bytes;
    logic [ADDR_W:0] target, wc_inc;
    logic            acc, hdr_acc, data_acc, we;
    logic [31:0]     rdata;
    logic            unused_pc;
    assign acc      = byte_valid && byte_ready;
    assign hdr_acc  = acc && !load_start && state == HDR;
    assign data_acc = acc && !load_start && state == DATA;
    assign we       = data_acc && byte_cnt == 2'd3;
    assign wc_inc   = word_count + 1'b1;
    always_comb begin
        nxt = state;
        if (load_start)
            nxt = HDR;
        else if (hdr_acc)
            nxt = int'(byte_in) > DEPTH ? ERR : DATA;
        else if (we && wc_inc == target)
            nxt = DONE;
    end
    // Status flags are decoded from the next state so they stay registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            byte_ready <= 1'b0;
            cpu_hold   <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            word_count <= '0;
            byte_cnt   <= '0;
            asm_bytes  <= '0;
            target     <= '0;
        end else begin
            state      <= nxt;
            byte_ready <= nxt == HDR || nxt == DATA;
            cpu_hold   <= nxt != DONE;
            load_done  <= nxt == DONE;
            load_err   <= nxt == ERR;
            if (load_start) begin
                word_count <= '0;
                byte_cnt   <= '0;
            end else if (hdr_acc) begin
                target <= byte_in == 8'd0 ? (ADDR_W+1)'(DEPTH) : (ADDR_W+1)'(byte_in);
            end else if (data_acc) begin
                byte_cnt  <= byte_cnt + 2'd1;
                asm_bytes <= {byte_in, asm_bytes[23:8]};
                if (byte_cnt == 2'd3) word_count <= wc_inc;
            end
        end
    end
    imem_array #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_array (
        .clk   (clk),
        .we    (we),
        .waddr (word_count[ADDR_W-1:0]),
        .wdata ({byte_in, asm_bytes}),
        .raddr (PC[ADDR_W+1:2]),
        .rdata (rdata)
    );
    assign instr     = state == DONE ? rdata : 32'h0000_0000;
    assign unused_pc = ^{PC[31:ADDR_W+2], PC[1:0]};
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed and randomized program loads checked against a
// word-array model of what the processor should read back.
module tb_imem_loader;
    import ssp_pkg::*;
    logic clk = 0, rst = 0, load_start = 0, byte_valid = 0;
    logic byte_ready, cpu_hold, load_done, load_err;
    logic [7:0] byte_in = 0;
    logic [31:0] PC = 0, instr;
    logic [IMEM_ADDR_W:0] word_count;
    int checks = 0, errors = 0;
    logic [31:0] model_mem [IMEM_DEPTH];

    imem_loader dut (
        .clk(clk), .rst(rst), .load_start(load_start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .PC(PC), .instr(instr),
        .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start;
        load_start = 1;
        tick;
        load_start = 0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        repeat (gap) tick;
        chk("byte_ready", 32'(byte_ready), 1);
        byte_valid = 1;
        byte_in = b;
        tick;
        byte_valid = 0;
        byte_in = 8'($urandom);
    endtask

    task automatic load_words(input int n, input int max_gap);
        logic [31:0] w;
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            model_mem[i] = w;
            for (int k = 0; k < 4; k++)
                send(8'((w >> (8 * k)) & 32'hFF), int'($urandom_range(0, max_gap)));
        end
    endtask

    task automatic read(input logic [31:0] pc);
        PC = pc;
        #1;
        chk("instr", instr, model_mem[int'((pc >> 2) % IMEM_DEPTH)]);
    endtask

    initial begin
        logic [7:0] prog [8];
        int n;
        prog = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        repeat (3) tick;
        chk("rst_cpu_hold", 32'(cpu_hold), 1);
        chk("rst_byte_ready", 32'(byte_ready), 0);
        chk("rst_load_done", 32'(load_done), 0);
        chk("rst_load_err", 32'(load_err), 0);
        chk("rst_word_count", 32'(word_count), 0);
        chk("rst_instr", instr, 0);
        rst = 1;
        for (int i = 0; i < 20; i++) begin
            tick;
            chk("idle_cpu_hold", 32'(cpu_hold), 1);
            chk("idle_byte_ready", 32'(byte_ready), 0);
            chk("idle_instr", instr, 0);
            chk("idle_load_done", 32'(load_done), 0);
        end

        start;
        send(8'h02, 0);
        for (int i = 0; i < 7; i++) send(prog[i], 0);
        chk("two_word_not_done", 32'(load_done), 0);
        send(prog[7], 0);
        chk("two_word_done", 32'(load_done), 1);
        chk("two_word_hold", 32'(cpu_hold), 0);
        model_mem[0] = 32'h12345678;
        model_mem[1] = 32'hDEADBEEF;
        PC = 0; #1 chk("pc0", instr, 32'h12345678);
        PC = 4; #1 chk("pc4", instr, 32'hDEADBEEF);
        PC = 32'h104; #1 chk("pc104_wrap", instr, 32'hDEADBEEF);
        PC = 32'h7; #1 chk("pc7_low_bits", instr, 32'hDEADBEEF);
        byte_valid = 1; byte_in = 8'h55;
        tick; tick;
        byte_valid = 0;
        read(0);
        read(4);
        chk("done_ignore_wc", 32'(word_count), 2);
        chk("done_ignore_ready", 32'(byte_ready), 0);

        start;
        send(8'h41, 0);
        chk("err_flag", 32'(load_err), 1);
        chk("err_ready", 32'(byte_ready), 0);
        chk("err_hold", 32'(cpu_hold), 1);
        PC = 0; #1 chk("err_instr", instr, 0);
        byte_valid = 1; tick; tick; byte_valid = 0;
        chk("err_sticky", 32'(load_err), 1);
        start;
        chk("err_cleared", 32'(load_err), 0);
        send(8'h01, 0);
        load_words(1, 0);
        chk("recover_err", 32'(load_err), 0);
        chk("recover_done", 32'(load_done), 1);
        read(0);

        start;
        send(8'h00, 0);
        load_words(IMEM_DEPTH, 3);
        chk("full_wc", 32'(word_count), IMEM_DEPTH);
        chk("full_done", 32'(load_done), 1);
        for (int i = 0; i < IMEM_DEPTH; i++)
            read(($urandom & 32'hFFFF_FF00) | 32'(i << 2) | $urandom_range(0, 3));

        repeat (3) begin
            n = int'($urandom_range(1, IMEM_DEPTH));
            start;
            send(8'(n), 0);
            load_words(n, 1);
            chk("rand_wc", 32'(word_count), 32'(n));
            chk("rand_done", 32'(load_done), 1);
            repeat (8) read($urandom);
        end

        start;
        send(8'h04, 0);
        load_words(2, 0);
        tick;
        #2 rst = 0;
        #1;
        chk("midrst_wc", 32'(word_count), 0);
        chk("midrst_hold", 32'(cpu_hold), 1);
        chk("midrst_ready", 32'(byte_ready), 0);
        chk("midrst_instr", instr, 0);
        #2 rst = 1;
        tick;
        start;
        send(8'h01, 0);
        send(8'h44, 0); send(8'h33, 0); send(8'h22, 0); send(8'h11, 0);
        model_mem[0] = 32'h11223344;
        PC = 0; #1 chk("midrst_reload", instr, 32'h11223344);
        chk("midrst_done", 32'(load_done), 1);

        start;
        send(8'h02, 0);
        send(8'hAA, 0);
        load_start = 1; byte_valid = 1; byte_in = 8'hBB;
        tick;
        load_start = 0; byte_valid = 0;
        chk("collide_ready", 32'(byte_ready), 1);
        chk("collide_wc", 32'(word_count), 0);
        chk("collide_done", 32'(load_done), 0);
        chk("collide_hold", 32'(cpu_hold), 1);
        send(8'h01, 0);
        load_words(1, 2);
        chk("collide_after_done", 32'(load_done), 1);
        chk("collide_after_wc", 32'(word_count), 1);
        read(0);
        read(32'h100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
